// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-divider configuration controller.
// Holds the controller state encoding, reset constants and the ratio legality test.
package clk_div_pkg;

  typedef enum logic [1:0] {
    HOLD,
    WAIT,
    RUN,
    FAULT
  } state_t;

  localparam state_t RST_STATE     = HOLD;
  localparam logic   RST_DIV_RST_N = 1'b0;
  localparam logic   RST_FLAG      = 1'b0;

  // A divider ratio is usable only when it is even and at least two.
  function automatic logic is_legal_div(input logic [31:0] num);
    return (num[0] == 1'b0) && (num >= 32'd2);
  endfunction

endpackage

// File: rtl/clk_toggle_mon.sv
// Watches the divided clock: keeps a registered copy, flags toggles and
// measures how long the output has been quiet while supervision is enabled.
module clk_toggle_mon
  import clk_div_pkg::*;
#(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_div,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic          toggle,
  output logic          gap_exceed
);

  logic          clk_div_q;
  logic [CW-1:0] gap_cnt;

  // The copy tracks clk_div every cycle; the gap counter saturates so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_div_q <= RST_FLAG;
      gap_cnt   <= '0;
    end else begin
      clk_div_q <= clk_div;
      if (!en || toggle) begin
        gap_cnt <= '0;
      end else if (gap_cnt != '1) begin
        gap_cnt <= gap_cnt + CW'(1);
      end
    end
  end

  assign toggle     = clk_div ^ clk_div_q;
  assign gap_exceed = gap_cnt > limit;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time ratio controller for the even-ratio clock divider: accepts ratio
// requests, sequences divider reset/release, confirms lock and supervises toggling.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int WIDTH_NUM_DIV = 4,
  parameter int DEFAULT_DIV   = 4,
  parameter int HOLD_CYC      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  input  logic [WIDTH_NUM_DIV-1:0] cfg_num,
  output logic                     cfg_ready,
  output logic                     cfg_err,
  input  logic                     clk_div,
  output logic [WIDTH_NUM_DIV-1:0] div_num,
  output logic                     div_rst_n,
  output logic                     locked,
  output logic                     lock_err
);

  localparam int CW = WIDTH_NUM_DIV + 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [WIDTH_NUM_DIV-1:0] DEFAULT_NUM = WIDTH_NUM_DIV'(DEFAULT_DIV);

  state_t                     state;
  state_t                     state_nxt;
  logic [WIDTH_NUM_DIV-1:0]   div_num_nxt;
  logic                       lock_err_nxt;
  logic                       cfg_err_nxt;
  logic [HW-1:0]              hold_cnt;
  logic [HW-1:0]              hold_cnt_nxt;
  logic [CW-1:0]              wait_cnt;
  logic [CW-1:0]              wait_cnt_nxt;
  logic [CW-1:0]              wait_inc;
  logic [CW-1:0]              div_num_ext;
  logic [CW-1:0]              gap_limit;
  logic                       toggle;
  logic                       gap_exceed;
  logic                       cfg_take;
  logic                       cfg_legal;

  assign div_num_ext = {1'b0, div_num};
  assign gap_limit   = (div_num_ext >> 1) + CW'(1);
  assign wait_inc    = wait_cnt + CW'(1);
  assign cfg_take    = cfg_valid && cfg_ready;
  assign cfg_legal   = is_legal_div(32'(cfg_num));

  clk_toggle_mon #(
    .CW (CW)
  ) u_mon (
    .clk        (clk),
    .rst        (rst),
    .clk_div    (clk_div),
    .en         (state == RUN),
    .limit      (gap_limit),
    .toggle     (toggle),
    .gap_exceed (gap_exceed)
  );

  // Sequencing first, then an accepted request takes priority over it.
  always_comb begin
    state_nxt    = state;
    div_num_nxt  = div_num;
    lock_err_nxt = lock_err;
    cfg_err_nxt  = 1'b0;
    hold_cnt_nxt = hold_cnt;
    wait_cnt_nxt = wait_cnt;

    case (state)
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt    = WAIT;
          hold_cnt_nxt = '0;
          wait_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt + HW'(1);
        end
      end
      WAIT: begin
        if (toggle) begin
          state_nxt = RUN;
        end else if (wait_inc >= div_num_ext) begin
          state_nxt    = FAULT;
          lock_err_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_inc;
        end
      end
      RUN: begin
        if (gap_exceed) begin
          state_nxt    = FAULT;
          lock_err_nxt = 1'b1;
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = HOLD;
      end
    endcase

    if (cfg_take) begin
      if (cfg_legal) begin
        state_nxt    = HOLD;
        div_num_nxt  = cfg_num;
        lock_err_nxt = 1'b0;
        hold_cnt_nxt = '0;
      end else begin
        cfg_err_nxt = 1'b1;
      end
    end
  end

  // Outputs are registered from the next state so no input reaches a port combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_STATE;
      div_num   <= DEFAULT_NUM;
      div_rst_n <= RST_DIV_RST_N;
      cfg_ready <= RST_FLAG;
      cfg_err   <= RST_FLAG;
      locked    <= RST_FLAG;
      lock_err  <= RST_FLAG;
      hold_cnt  <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      div_num   <= div_num_nxt;
      div_rst_n <= (state_nxt != HOLD);
      cfg_ready <= (state_nxt == RUN) || (state_nxt == FAULT);
      cfg_err   <= cfg_err_nxt;
      locked    <= (state_nxt == RUN);
      lock_err  <= lock_err_nxt;
      hold_cnt  <= hold_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl with a behavioural even-ratio
// divider attached; the divider output can be frozen to emulate a dead clock.
module tb_clk_div_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic [3:0] cfg_num;
  logic       cfg_ready;
  logic       cfg_err;
  logic       clk_div;
  logic [3:0] div_num;
  logic       div_rst_n;
  logic       locked;
  logic       lock_err;

  logic       stuck_en;
  logic       stuck_val;
  logic       dout;
  int         dcnt;

  int checks;
  int errors;

  clk_div_ctrl #(
    .WIDTH_NUM_DIV (4),
    .DEFAULT_DIV   (4),
    .HOLD_CYC      (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_num   (cfg_num),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_div   (clk_div),
    .div_num   (div_num),
    .div_rst_n (div_rst_n),
    .locked    (locked),
    .lock_err  (lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural divider: output toggles every div_num/2 edges once out of reset.
  always @(posedge clk) begin
    if (!div_rst_n) begin
      dcnt <= 0;
      dout <= 1'b0;
    end else if (dcnt >= int'(div_num) / 2 - 1) begin
      dcnt <= 0;
      dout <= ~dout;
    end else begin
      dcnt <= dcnt + 1;
    end
  end

  assign clk_div = stuck_en ? stuck_val : dout;

  task automatic measure_period(input int exp, input string tag);
    logic prev;
    bit   found;
    int   cnt;
    found = 1'b0;
    cnt   = 0;
    prev  = clk_div;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!prev && clk_div) begin
        found = 1'b1;
        break;
      end
      prev = clk_div;
    end
    if (found) begin
      found = 1'b0;
      prev  = clk_div;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        cnt++;
        if (!prev && clk_div) begin
          found = 1'b1;
          break;
        end
        prev = clk_div;
      end
    end
    checks++;
    if (!found || cnt != exp) begin
      errors++;
      $display("[TB] FAIL %s: period got %0d (found=%0d) expected %0d", tag, cnt, found, exp);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_num   = 4'd0;
    stuck_en  = 1'b0;
    stuck_val = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (div_num !== 4'd4) begin errors++; $display("[TB] FAIL reset_div_num: got %0d expected 4", div_num); end
    checks++; if (div_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_div_rst_n: got %b expected 0", div_rst_n); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_cfg_ready: got %b expected 0", cfg_ready); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_cfg_err: got %b expected 0", cfg_err); end
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %b expected 0", locked); end
    checks++; if (lock_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_lock_err: got %b expected 0", lock_err); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (div_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL start_hold: div_rst_n got %b expected 0", div_rst_n); end
    @(negedge clk);
    checks++; if (div_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL start_release: div_rst_n got %b expected 1", div_rst_n); end
    repeat (2) @(negedge clk);
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL start_early_lock: locked got %b expected 0", locked); end
    @(negedge clk);
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL start_lock: locked got %b expected 1", locked); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL start_ready: cfg_ready got %b expected 1", cfg_ready); end
  endtask

  task automatic test_reconfig();
    cfg_valid = 1'b1;
    cfg_num   = 4'd6;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++; if (div_num !== 4'd6) begin errors++; $display("[TB] FAIL reconfig_div_num: got %0d expected 6", div_num); end
    checks++; if (div_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL reconfig_hold1: div_rst_n got %b expected 0", div_rst_n); end
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reconfig_unlock: locked got %b expected 0", locked); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL reconfig_busy: cfg_ready got %b expected 0", cfg_ready); end
    @(negedge clk);
    checks++; if (div_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL reconfig_hold2: div_rst_n got %b expected 0", div_rst_n); end
    @(negedge clk);
    checks++; if (div_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL reconfig_release: div_rst_n got %b expected 1", div_rst_n); end
    repeat (3) @(negedge clk);
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reconfig_early_lock: locked got %b expected 0", locked); end
    @(negedge clk);
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL reconfig_lock: locked got %b expected 1", locked); end
    measure_period(6, "reconfig_period6");
  endtask

  task automatic test_illegal();
    logic [3:0] bad [3];
    bad[0] = 4'd5;
    bad[1] = 4'd0;
    bad[2] = 4'd1;
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1;
      cfg_num   = bad[i];
      @(negedge clk);
      cfg_valid = 1'b0;
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err_%0d: cfg_err got %b expected 1", bad[i], cfg_err); end
      checks++; if (div_num !== 4'd6) begin errors++; $display("[TB] FAIL illegal_div_%0d: div_num got %0d expected 6", bad[i], div_num); end
      checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL illegal_lock_%0d: locked got %b expected 1", bad[i], locked); end
      @(negedge clk);
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL illegal_pulse_%0d: cfg_err got %b expected 0", bad[i], cfg_err); end
      checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL illegal_hold_%0d: locked got %b expected 1", bad[i], locked); end
    end
  endtask

  task automatic test_same_ratio();
    cfg_valid = 1'b1;
    cfg_num   = 4'd6;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL same_unlock: locked got %b expected 0", locked); end
    checks++; if (div_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL same_hold: div_rst_n got %b expected 0", div_rst_n); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL same_err: cfg_err got %b expected 0", cfg_err); end
    repeat (5) @(negedge clk);
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL same_early_lock: locked got %b expected 0", locked); end
    @(negedge clk);
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL same_lock: locked got %b expected 1", locked); end
  endtask

  task automatic test_lock_timeout();
    cfg_valid = 1'b1;
    cfg_num   = 4'd8;
    stuck_en  = 1'b1;
    stuck_val = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (lock_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early: lock_err got %b expected 0", lock_err); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL timeout_busy: cfg_ready got %b expected 0", cfg_ready); end
    @(negedge clk);
    checks++; if (lock_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err: lock_err got %b expected 1", lock_err); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL timeout_ready: cfg_ready got %b expected 1", cfg_ready); end
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL timeout_locked: locked got %b expected 0", locked); end
    checks++; if (div_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL timeout_rst_n: div_rst_n got %b expected 1", div_rst_n); end
    cfg_valid = 1'b1;
    cfg_num   = 4'd3;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL fault_illegal_err: cfg_err got %b expected 1", cfg_err); end
    checks++; if (lock_err !== 1'b1) begin errors++; $display("[TB] FAIL fault_illegal_sticky: lock_err got %b expected 1", lock_err); end
    checks++; if (div_num !== 4'd8) begin errors++; $display("[TB] FAIL fault_illegal_div: div_num got %0d expected 8", div_num); end
    stuck_en  = 1'b0;
    cfg_valid = 1'b1;
    cfg_num   = 4'd4;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++; if (lock_err !== 1'b0) begin errors++; $display("[TB] FAIL recover_clear: lock_err got %b expected 0", lock_err); end
    checks++; if (div_num !== 4'd4) begin errors++; $display("[TB] FAIL recover_div: div_num got %0d expected 4", div_num); end
    repeat (4) @(negedge clk);
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL recover_early_lock: locked got %b expected 0", locked); end
    @(negedge clk);
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL recover_lock: locked got %b expected 1", locked); end
  endtask

  task automatic test_toggle_loss();
    logic prev;
    bit   found;
    found = 1'b0;
    prev  = clk_div;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (clk_div !== prev) begin
        found = 1'b1;
        break;
      end
      prev = clk_div;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL loss_sync: no divider toggle within 10 cycles, expected one"); end
    stuck_val = clk_div;
    stuck_en  = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL loss_early: locked got %b expected 1", locked); end
    checks++; if (lock_err !== 1'b0) begin errors++; $display("[TB] FAIL loss_early_err: lock_err got %b expected 0", lock_err); end
    @(negedge clk);
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL loss_unlock: locked got %b expected 0", locked); end
    checks++; if (lock_err !== 1'b1) begin errors++; $display("[TB] FAIL loss_err: lock_err got %b expected 1", lock_err); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL loss_ready: cfg_ready got %b expected 1", cfg_ready); end
  endtask

  task automatic test_reset_in_wait();
    stuck_en  = 1'b0;
    cfg_valid = 1'b1;
    cfg_num   = 4'd14;
    @(negedge clk);
    checks++; if (div_num !== 4'd14) begin errors++; $display("[TB] FAIL rstwait_accept: div_num got %0d expected 14", div_num); end
    cfg_num = 4'd6;
    repeat (2) @(negedge clk);
    checks++; if (div_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL rstwait_in_wait: div_rst_n got %b expected 1", div_rst_n); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstwait_busy: cfg_ready got %b expected 0", cfg_ready); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (div_num !== 4'd4) begin errors++; $display("[TB] FAIL rstwait_default: div_num got %0d expected 4", div_num); end
    checks++; if (div_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL rstwait_rst_n: div_rst_n got %b expected 0", div_rst_n); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstwait_ready: cfg_ready got %b expected 0", cfg_ready); end
    rst       = 1'b0;
    cfg_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL rstwait_early_lock: locked got %b expected 0", locked); end
    @(negedge clk);
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL rstwait_relock: locked got %b expected 1", locked); end
    cfg_valid = 1'b1;
    cfg_num   = 4'd14;
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL max_early_lock: locked got %b expected 0", locked); end
    @(negedge clk);
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL max_lock: locked got %b expected 1", locked); end
    measure_period(14, "max_period14");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_reconfig();
    test_illegal();
    test_same_ratio();
    test_lock_timeout();
    test_toggle_loss();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time configuration controller for the even-ratio clock divider. Accepts divide-ratio requests over a valid/ready handshake, rejects illegal ratios, and applies each accepted ratio by holding the divider in reset, releasing it, and confirming lock on the first output toggle. Continuously monitors the divided clock and flags loss of toggling. Sits between the configuration/CSR logic and the divider instance, driving the divider's `num_div` and `rst_n` inputs.

## Interface
- `WIDTH_NUM_DIV`, 4: width of divide-ratio fields, matching the divider.
- `DEFAULT_DIV`, 4: ratio applied after reset; must be even and ≥2.
- `HOLD_CYC`, 2: cycles `div_rst_n` is held low per reconfiguration, ≥1.
- `clk`  in  1  single system clock; divider runs on the same clock.
- `rst`  in  1  reset: one clock, synchronous, active-high.
- `cfg_valid`  in  1  ratio request valid.
- `cfg_num`  in  WIDTH_NUM_DIV  requested divide ratio.
- `cfg_ready`  out  1  controller can accept a request.
- `cfg_err`  out  1  one-cycle pulse: accepted request was illegal and was discarded.
- `clk_div`  in  1  divider output, sampled on `clk`.
- `div_num`  out  WIDTH_NUM_DIV  ratio driven to divider.
- `div_rst_n`  out  1  active-low reset to divider.
- `locked`  out  1  divider running at `div_num` and toggling.
- `lock_err`  out  1  sticky: lock timeout or toggle loss.

## Operation
- States: HOLD, WAIT, RUN, FAULT.
- Reset values: state HOLD, `div_num`=DEFAULT_DIV, `div_rst_n`=0, `cfg_ready`=0, `cfg_err`=0, `locked`=0, `lock_err`=0, counters 0. After reset, the controller runs the start sequence with DEFAULT_DIV automatically.
- HOLD: `div_rst_n`=0 for HOLD_CYC cycles → WAIT.
- WAIT: `div_rst_n`=1, wait counter increments each cycle. A toggle (`clk_div` ≠ registered copy) moves to RUN. If the counter reaches `div_num` (twice the expected `div_num`/2) without a toggle, move to FAULT and set `lock_err`.
- RUN: `locked`=1 and `cfg_ready`=1.
  - Gap counter clears on every toggle.
  - If the gap counter exceeds `div_num`/2+1, move to FAULT, clear `locked` and set `lock_err`.
- FAULT: `locked`=0, `cfg_ready`=1, `div_rst_n`=1. State held until a request or reset.
- Handshake: a transfer occurs on an edge with `cfg_valid`&&`cfg_ready`. `cfg_ready` is 0 in HOLD and WAIT, and `cfg_valid` may wait there indefinitely.
- Legality: `cfg_num` is legal iff it is even and ≥2. The maximum legal value is 2^WIDTH_NUM_DIV−2. The value 0, 1 or any odd value is illegal.
- Legal transfer:
  - `div_num` ← `cfg_num`; `locked`, `lock_err` ← 0; state → HOLD.
  - This applies even if `cfg_num` equals the current `div_num`.
- Illegal transfer: `cfg_err` pulses for one cycle and state, `div_num`, `locked` and `lock_err` are unchanged. An illegal request does not clear `lock_err` in FAULT.
- `rst` overrides all inputs, including a handshake on the same edge. Reset mid-sequence restarts with DEFAULT_DIV, not the last programmed ratio.

## Timing
- All outputs are registered, with no combinational input→output paths.
- Legal accept at edge E: `div_num` is new and `div_rst_n`=0 from E+1 for HOLD_CYC cycles. `div_rst_n`=1 from E+1+HOLD_CYC.
- The divider's first toggle is `div_num`/2 edges after release. `locked` rises one edge after the toggle is sampled.
- `cfg_err` is high exactly in the cycle after the accepting edge.
- Toggle detection uses a one-flop registered copy of `clk_div`. That copy is updated every cycle, including during HOLD.
- Counter width is WIDTH_NUM_DIV+1, with no wrap before the timeout.

## Structure
- Package `clk_div_pkg`:
  - state enum (HOLD, WAIT, RUN, FAULT);
  - function `is_legal_div(num)`;
  - reset constants.
- Sub-module `clk_toggle_mon`: registered `clk_div` copy, toggle pulse, and gap counter with a limit compare. The FSM stays in `clk_div_ctrl`.

## Test plan
- Reset release with DEFAULT_DIV=4 and HOLD_CYC=2, divider attached → `div_rst_n` low for 2 cycles after reset, `locked`=1 within 2+2+2 cycles, `cfg_ready`=1.
- In RUN, `cfg_num`=6 accepted at E → `div_rst_n` low at E+1..E+2, `div_num`=6, `locked` at E+6, `clk_div` period 6.
- In RUN, `cfg_num`=5, then 0, then 1 → each transfer produces a one-cycle `cfg_err`, with `div_num` and `locked` unchanged.
- Divider replaced by a stuck-0 `clk_div` after a legal `cfg_num`=8 → FAULT, `lock_err`=1 8 cycles after release, `cfg_ready`=1. A subsequent legal request with a working divider clears `lock_err` and relocks.
- In RUN with `div_num`=4, force `clk_div` stuck → `locked` falls and `lock_err` rises once the gap exceeds 3 cycles.
- `rst` asserted in WAIT in the same edge as a held `cfg_valid` → request ignored, `div_num`=DEFAULT_DIV, start sequence restarts. `cfg_num`=14 (WIDTH 4) locks with period 14.
